// File: rtl/ptt_stream_decoder_pkg.sv
// Shared types, constants and the PTT->EBCDIC translation table for the
// streaming PTT decoder.
package ptt_stream_decoder_pkg;

    localparam int unsigned PTT_W = 6;
    localparam int unsigned EBC_W = 8;

    // PTT codes with fixed meaning
    localparam logic [PTT_W-1:0] PTT_UPSHIFT   = 6'o34;
    localparam logic [PTT_W-1:0] PTT_DOWNSHIFT = 6'o37;
    localparam logic [PTT_W-1:0] PTT_ZERO      = 6'o12;
    localparam logic [PTT_W-1:0] PTT_SPACE     = 6'o20;
    localparam logic [PTT_W-1:0] PTT_NL        = 6'o55;

    // EBCDIC constants
    localparam logic [EBC_W-1:0] E_NL  = 8'h15;
    localparam logic [EBC_W-1:0] E_SP  = 8'h40;
    localparam logic [EBC_W-1:0] E_SUB = 8'h3F;

    typedef enum logic [1:0] {
        CS_TRACK  = 2'b00,
        CS_LOWER  = 2'b01,
        CS_UPPER  = 2'b10,
        CS_TRACK2 = 2'b11
    } case_sel_e;

    typedef enum logic {
        ST_LOWER = 1'b0,
        ST_UPPER = 1'b1
    } shift_state_e;

    // Lookup request carried down the pipeline
    typedef struct packed {
        logic             upper;
        logic [PTT_W-1:0] code;
    } lut_req_t;

    // Translation table; 0 marks an unmapped code.
    // Digits and punctuation are case-independent, letters use the
    // lower (8x/9x/Ax) or upper (Cx/Dx/Ex) EBCDIC zones.
    function automatic logic [EBC_W-1:0] ptt_to_ebcdic(input logic upper,
                                                      input logic [PTT_W-1:0] code);
        logic [EBC_W-1:0] r;
        r = '0;
        if (code >= 6'o01 && code <= 6'o11)      r = 8'hF0 + EBC_W'(code);
        else if (code == PTT_ZERO)               r = 8'hF0;
        else if (code == PTT_SPACE)              r = E_SP;
        else if (code == PTT_NL)                 r = E_NL;
        else if (code >= 6'o22 && code <= 6'o31) r = (upper ? 8'hE0 : 8'hA0) + EBC_W'(code - 6'o20);
        else if (code >= 6'o41 && code <= 6'o51) r = (upper ? 8'hD0 : 8'h90) + EBC_W'(code - 6'o40);
        else if (code >= 6'o61 && code <= 6'o71) r = (upper ? 8'hC0 : 8'h80) + EBC_W'(code - 6'o60);
        return r;
    endfunction

endpackage

// File: rtl/ptt_stream_decoder_if.sv
// Handshake bundle of the PTT decoder: code input side, byte output side
// and status. slave = decoder view, master = driver/monitor view.
interface ptt_stream_decoder_if;
    import ptt_stream_decoder_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [PTT_W-1:0] i_ptt;
    logic [1:0]       i_case_sel;
    logic             o_valid;
    logic             i_ready;
    logic [EBC_W-1:0] o_data;
    logic             o_upper;
    logic [7:0]       o_err_count;

    modport slave (
        input  i_valid, i_ptt, i_case_sel, i_ready,
        output o_ready, o_valid, o_data, o_upper, o_err_count
    );

    modport master (
        output i_valid, i_ptt, i_case_sel, i_ready,
        input  o_ready, o_valid, o_data, o_upper, o_err_count
    );

endinterface

// File: rtl/ptt_stream_decoder_ebcdic_lut.sv
// LAT-stage lookup pipeline. The {upper, code} request and its valid bit
// are registered LAT times; the table is read from the last stage register,
// so the translated byte appears LAT cycles after the request is presented.
// Ports: i_clk, i_reset_n; i_valid/i_req request in;
//        o_valid, o_invalid_c (unmapped code), o_data_c (translated byte).
module ptt_ebcdic_lut
    import ptt_stream_decoder_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  lut_req_t         i_req,
    output logic             o_valid,
    output logic             o_invalid_c,
    output logic [EBC_W-1:0] o_data_c
);

    logic [LAT-1:0] vld_q;
    lut_req_t       req_q [LAT];
    logic [EBC_W-1:0] data_c;

    // Pipeline shift register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) req_q[i] <= '0;
        end else begin
            vld_q[0] <= i_valid;
            req_q[0] <= i_req;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                req_q[i] <= req_q[i-1];
            end
        end
    end

    assign data_c      = ptt_to_ebcdic(req_q[LAT-1].upper, req_q[LAT-1].code);
    assign o_valid     = vld_q[LAT-1];
    assign o_invalid_c = (data_c == '0);
    assign o_data_c    = data_c;

endmodule

// File: rtl/ptt_stream_decoder.sv
// Streaming PTT -> EBCDIC decoder. Tracks shift state from in-band
// UPSHIFT/DOWNSHIFT codes, translates through a pipelined table and
// buffers bytes in an output FIFO with valid/ready on both sides.
// Ports: i_clk, i_reset_n (async, active low);
//        bus.slave: i_valid/o_ready/i_ptt/i_case_sel code input,
//                   o_valid/i_ready/o_data byte output,
//                   o_upper shift state, o_err_count unmapped-code count.
module ptt_stream_decoder
    import ptt_stream_decoder_pkg::*;
#(
    parameter int unsigned      LAT          = 2,
    parameter int unsigned      DEPTH        = 8,
    parameter logic [PTT_W-1:0] UPSHIFT      = PTT_UPSHIFT,
    parameter logic [PTT_W-1:0] DOWNSHIFT    = PTT_DOWNSHIFT,
    parameter logic             RESET_UC     = 1'b0,
    parameter logic             DROP_INVALID = 1'b0,
    parameter logic [EBC_W-1:0] SUB_CHAR     = E_SUB
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    ptt_stream_decoder_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam shift_state_e RESET_ST = RESET_UC ? ST_UPPER : ST_LOWER;

    shift_state_e     state_q, state_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [7:0]       err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [EBC_W-1:0] mem_q [DEPTH];

    logic             accept_c, is_up_c, is_dn_c, lut_in_c, case_upper_c;
    logic             lut_vld_c, lut_inv_c, push_c, pop_c;
    logic [EBC_W-1:0] lut_data_c, push_data_c;
    lut_req_t         lut_req_c;

    assign accept_c = bus.i_valid & ready_q;
    assign is_up_c  = (bus.i_ptt == UPSHIFT);
    assign is_dn_c  = (bus.i_ptt == DOWNSHIFT);
    // Shift codes are consumed here and never occupy a pipeline slot
    assign lut_in_c = accept_c & ~is_up_c & ~is_dn_c;

    // Lookup case: forced by i_case_sel or taken from the shift FSM
    always_comb begin
        case_upper_c = (state_q == ST_UPPER);
        case (case_sel_e'(bus.i_case_sel))
            CS_LOWER: case_upper_c = 1'b0;
            CS_UPPER: case_upper_c = 1'b1;
            default:  case_upper_c = (state_q == ST_UPPER);
        endcase
    end

    assign lut_req_c = '{upper: case_upper_c, code: bus.i_ptt};

    ptt_ebcdic_lut #(.LAT(LAT)) u_lut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (lut_in_c),
        .i_req       (lut_req_c),
        .o_valid     (lut_vld_c),
        .o_invalid_c (lut_inv_c),
        .o_data_c    (lut_data_c)
    );

    assign push_c      = lut_vld_c & ~(lut_inv_c & DROP_INVALID);
    assign push_data_c = lut_inv_c ? SUB_CHAR : lut_data_c;
    assign pop_c       = (count_q != '0) & bus.i_ready;

    // Shift FSM, counters and ready reservation
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        inflight_d = inflight_q + CNT_W'(lut_in_c) - CNT_W'(lut_vld_c);
        if (accept_c && is_up_c)      state_d = ST_UPPER;
        else if (accept_c && is_dn_c) state_d = ST_LOWER;
        if (lut_vld_c && lut_inv_c && err_q != 8'hFF) err_d = err_q + 8'd1;
        // Every code in the pipeline already owns a FIFO slot
        ready_d = (SUM_W'(count_d) + SUM_W'(inflight_d)) < SUM_W'(DEPTH);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= RESET_ST;
            ready_q    <= 1'b0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Output FIFO storage and pointers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= push_data_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_valid     = (count_q != '0);
    assign bus.o_data      = mem_q[rd_ptr_q];
    assign bus.o_upper     = (state_q == ST_UPPER);
    assign bus.o_err_count = err_q;

endmodule
